// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit. The control unit
// imports the same state encoding so its stall decode follows the unit state.
//   OP_MUL / OP_DIV : encoding of the op_div request bit
//   mdu_state_t     : S_IDLE -> S_RUN -> S_DONE -> S_IDLE
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Request/result bundle between the EX-stage control and the multiply/divide
// unit.
//   start, op_div, operand_a, operand_b : request side (driven by master)
//   busy, done, hi, lo, div_by_zero     : status/result side (driven by slave)
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(parameter int WIDTH = 8);

  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_by_zero;

  modport master (
    output start, op_div, operand_a, operand_b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, op_div, operand_a, operand_b,
    output busy, done, hi, lo, div_by_zero
  );

endinterface

// File: rtl/mult_div_unit_step.sv
// -----------------------------------------------------------------------------
// mdu_step
// One combinational iteration of both algorithms; the top picks the result
// that matches the latched operation.
//   acc      : 2*WIDTH shift-add accumulator, multiplier sits in the low half
//   rem      : WIDTH+1 bit partial remainder
//   quo      : dividend bits still to be consumed / quotient bits shifted in
//   operand  : multiplicand (multiply) or divisor (divide)
//   *_next   : values after this iteration
// -----------------------------------------------------------------------------
module mdu_step #(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH:0]     rem,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH:0]     rem_next,
  output logic [WIDTH-1:0]   quo_next
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Multiply: add the multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole accumulator right by one.
  // The carry out of the add becomes the new top bit, so nothing is lost.
  // Divide: bring the next dividend bit into the remainder and try the
  // subtract; a borrow (top bit set) means restore and shift in a 0.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};

    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {2'b00, operand};
    if (trial[WIDTH+1]) begin
      rem_next = shifted[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative unsigned multiply/divide (MULTU/DIVU) producing a HI/LO pair.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : slave side of mult_div_unit_if
//                start/op_div/operand_a/operand_b in, busy/done/hi/lo/
//                div_by_zero out
// A request takes WIDTH iterations; divide by zero finishes immediately.
// hi/lo are only written when a result is complete.
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t         state_q, state_d;
  logic [CW-1:0]      count_q;
  logic               op_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               dbz_q;

  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;

  logic accept, zero_div, last_iter;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .rem      (rem_q),
    .quo      (quo_q),
    .operand  (opnd_q),
    .acc_next (acc_next),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode. Requests are only taken in IDLE; a divide by zero
  // has a fixed answer and skips the iterations entirely.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    zero_div  = 1'b0;
    last_iter = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (bus.op_div == OP_DIV && bus.operand_b == '0) begin
            zero_div = 1'b1;
            state_d  = S_DONE;
          end else begin
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (count_q == CW'(WIDTH - 1)) begin
          last_iter = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath. Operands are captured into the working registers at
  // acceptance, so later changes on the bus cannot disturb the result.
  // The counter freezes on the final iteration, and hi/lo are written
  // only there (or at acceptance of a divide by zero).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      op_q    <= OP_MUL;
      opnd_q  <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      op_q    <= bus.op_div;
      opnd_q  <= (bus.op_div == OP_DIV) ? bus.operand_b : bus.operand_a;
      acc_q   <= {{WIDTH{1'b0}}, bus.operand_b};
      rem_q   <= '0;
      quo_q   <= bus.operand_a;
      count_q <= '0;
      dbz_q   <= zero_div;
      if (zero_div) begin
        hi_q <= bus.operand_a;
        lo_q <= '1;
      end
    end else if (state_q == S_RUN) begin
      acc_q <= acc_next;
      rem_q <= rem_next;
      quo_q <= quo_next;
      if (last_iter) begin
        if (op_q == OP_DIV) begin
          hi_q <= rem_next[WIDTH-1:0];
          lo_q <= quo_next;
        end else begin
          hi_q <= acc_next[2*WIDTH-1:WIDTH];
          lo_q <= acc_next[WIDTH-1:0];
        end
      end else begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.busy        = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: a behavioural model built from plain
// arithmetic (a*b, a/b, a%b) plus transaction timing is compared against the
// DUT on every falling edge; directed cases pin literal results.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  int checkCount = 0;
  int passCount  = 0;

  mult_div_unit_if #(.WIDTH(WIDTH)) bus ();

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference state: cycles of RUN still to go, done pulse, pending result
  // and the committed HI/LO/div_by_zero that must be visible on the outputs.
  int             m_run_left;
  bit             m_in_done;
  logic [WIDTH-1:0] m_hi, m_lo, p_hi, p_lo;
  bit             m_dbz;

  // Compare one observed value against its required value.
  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model. An accepted request yields WIDTH busy cycles and then
  // a one-cycle done, except divide by zero, which is done straight away.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run_left <= 0;
      m_in_done  <= 1'b0;
      m_hi       <= '0;
      m_lo       <= '0;
      p_hi       <= '0;
      p_lo       <= '0;
      m_dbz      <= 1'b0;
    end else if (m_in_done) begin
      m_in_done <= 1'b0;
    end else if (m_run_left != 0) begin
      m_run_left <= m_run_left - 1;
      if (m_run_left == 1) begin
        m_hi      <= p_hi;
        m_lo      <= p_lo;
        m_in_done <= 1'b1;
      end
    end else if (bus.start) begin
      m_dbz <= 1'b0;
      if (bus.op_div && bus.operand_b == 0) begin
        m_hi      <= bus.operand_a;
        m_lo      <= '1;
        m_dbz     <= 1'b1;
        m_in_done <= 1'b1;
      end else begin
        m_run_left <= WIDTH;
        if (bus.op_div) begin
          p_hi <= bus.operand_a % bus.operand_b;
          p_lo <= bus.operand_a / bus.operand_b;
        end else begin
          {p_hi, p_lo} <= {8'h00, bus.operand_a} * {8'h00, bus.operand_b};
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("busy",        {15'd0, bus.busy},        {15'd0, (m_run_left != 0)});
    checkOutput("done",        {15'd0, bus.done},        {15'd0, m_in_done});
    checkOutput("hi",          {8'd0, bus.hi},           {8'd0, m_hi});
    checkOutput("lo",          {8'd0, bus.lo},           {8'd0, m_lo});
    checkOutput("div_by_zero", {15'd0, bus.div_by_zero}, {15'd0, m_dbz});
  end

  // Issue one request once the unit is idle, scramble the bus afterwards,
  // and wait for done; reports latency (falling edges after acceptance)
  // and how many of those samples showed busy.
  task automatic applyStimulus(input logic op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b,
                               output int latency, output int busyCycles);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checkCount++;
      $display("[TB] FAIL idle_wait: unit still busy after %0d cycles, required idle", guard);
    end
    bus.start     = 1'b1;
    bus.op_div    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(negedge clk);
    latency    = 1;
    busyCycles = bus.busy ? 1 : 0;
    bus.start     = 1'b0;
    bus.operand_a = WIDTH'($urandom);
    bus.operand_b = WIDTH'($urandom);
    bus.op_div    = 1'($urandom);
    while (!bus.done && latency < 40) begin
      @(negedge clk);
      latency++;
      if (bus.busy) busyCycles++;
    end
    if (!bus.done) begin
      checkCount++;
      $display("[TB] FAIL done_wait: no done after %0d cycles, required within %0d", latency, WIDTH + 1);
    end
  endtask

  int lat, bc;

  initial begin
    bus.start     = 1'b0;
    bus.op_div    = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {15'd0, bus.busy}, 16'd0);
    checkOutput("rst_done", {15'd0, bus.done}, 16'd0);
    checkOutput("rst_hi",   {8'd0, bus.hi},    16'd0);
    checkOutput("rst_lo",   {8'd0, bus.lo},    16'd0);
    checkOutput("rst_dbz",  {15'd0, bus.div_by_zero}, 16'd0);
    rst_n = 1'b1;

    $display("[TB] directed multiply/divide cases");
    applyStimulus(1'b0, 8'd13, 8'd11, lat, bc);
    checkOutput("t1_latency", 16'(lat), 16'd9);
    checkOutput("t1_busy_cycles", 16'(bc), 16'd8);
    checkOutput("t1_hi", {8'd0, bus.hi}, 16'h00);
    checkOutput("t1_lo", {8'd0, bus.lo}, 16'h8F);
    checkOutput("t1_dbz", {15'd0, bus.div_by_zero}, 16'd0);

    applyStimulus(1'b0, 8'd255, 8'd255, lat, bc);
    checkOutput("t2a_hi", {8'd0, bus.hi}, 16'hFE);
    checkOutput("t2a_lo", {8'd0, bus.lo}, 16'h01);
    applyStimulus(1'b0, 8'd0, 8'd200, lat, bc);
    checkOutput("t2b_hi", {8'd0, bus.hi}, 16'h00);
    checkOutput("t2b_lo", {8'd0, bus.lo}, 16'h00);

    applyStimulus(1'b1, 8'd200, 8'd7, lat, bc);
    checkOutput("t3a_lo", {8'd0, bus.lo}, 16'h1C);
    checkOutput("t3a_hi", {8'd0, bus.hi}, 16'h04);
    applyStimulus(1'b1, 8'd5, 8'd9, lat, bc);
    checkOutput("t3b_lo", {8'd0, bus.lo}, 16'h00);
    checkOutput("t3b_hi", {8'd0, bus.hi}, 16'h05);
    applyStimulus(1'b1, 8'd255, 8'd1, lat, bc);
    checkOutput("t3c_lo", {8'd0, bus.lo}, 16'hFF);
    checkOutput("t3c_hi", {8'd0, bus.hi}, 16'h00);

    applyStimulus(1'b1, 8'd42, 8'd0, lat, bc);
    checkOutput("t4_latency", 16'(lat), 16'd1);
    checkOutput("t4_busy_cycles", 16'(bc), 16'd0);
    checkOutput("t4_lo", {8'd0, bus.lo}, 16'hFF);
    checkOutput("t4_hi", {8'd0, bus.hi}, 16'h2A);
    checkOutput("t4_dbz", {15'd0, bus.div_by_zero}, 16'd1);
    applyStimulus(1'b0, 8'd2, 8'd3, lat, bc);
    checkOutput("t4_next_lo", {8'd0, bus.lo}, 16'h06);
    checkOutput("t4_next_dbz", {15'd0, bus.div_by_zero}, 16'd0);

    $display("[TB] start held high with operands changing every cycle");
    @(negedge clk);
    for (int i = 0; i < 60; i++) begin
      bus.start     = 1'b1;
      bus.op_div    = 1'($urandom);
      bus.operand_a = WIDTH'($urandom);
      bus.operand_b = ($urandom_range(0, 7) == 0) ? '0 : WIDTH'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;

    $display("[TB] randomized requests with random gaps");
    for (int i = 0; i < 2500; i++) begin
      bus.start     = ($urandom_range(0, 2) == 0);
      bus.op_div    = 1'($urandom);
      bus.operand_a = WIDTH'($urandom);
      bus.operand_b = ($urandom_range(0, 9) == 0) ? '0 : WIDTH'($urandom);
      @(negedge clk);
    end
    bus.start = 1'b0;

    $display("[TB] reset in the middle of a multiply");
    applyStimulus(1'b0, 8'd200, 8'd100, lat, bc);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op_div    = 1'b0;
    bus.operand_a = 8'd9;
    bus.operand_b = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("t6_busy_before", {15'd0, bus.busy}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_busy", {15'd0, bus.busy}, 16'd0);
    checkOutput("t6_rst_done", {15'd0, bus.done}, 16'd0);
    checkOutput("t6_rst_hi",   {8'd0, bus.hi},    16'd0);
    checkOutput("t6_rst_lo",   {8'd0, bus.lo},    16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'd3, 8'd4, lat, bc);
    checkOutput("t6_after_lo", {8'd0, bus.lo}, 16'h0C);
    checkOutput("t6_after_hi", {8'd0, bus.hi}, 16'h00);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
